// File: rtl/fill_span_engine.sv
// fill_span_engine: walks one clipped scanline span and writes every pixel of it
// to the frame-buffer write port, then pulses fill_done once.
module fill_span_engine #(
   parameter int X_W      = 10,
   parameter int Y_W      = 9,
   parameter int SCREEN_W = 640,
   parameter int COLOR_W  = 8,
   parameter int ADDR_W   = 19
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               fill_start,
   input  logic [Y_W-1:0]     row_y,
   input  logic [X_W-1:0]     x_a,
   input  logic [X_W-1:0]     x_b,
   input  logic [COLOR_W-1:0] color,
   input  logic               wr_ready,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [COLOR_W-1:0] wr_data,
   output logic               fill_done,
   output logic               busy
);

   localparam logic [X_W-1:0]    X_MAX  = X_W'(SCREEN_W - 1);
   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(SCREEN_W);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE, S_REARM} state_t;

   // Span request as captured from the controller in IDLE.
   typedef struct packed {
      logic [Y_W-1:0]     row;
      logic [X_W-1:0]     xa;
      logic [X_W-1:0]     xb;
      logic [COLOR_W-1:0] color;
   } span_req_t;

   state_t            state, state_nxt;
   span_req_t         req;
   logic [X_W-1:0]    x, x_last;
   logic [ADDR_W-1:0] base;
   logic [X_W-1:0]    lo, hi_raw, hi;
   logic              span_empty;
   logic              last_px;

   // Order the endpoints, clip the top end to the screen, detect an off-screen span.
   always_comb begin
      lo         = (req.xa < req.xb) ? req.xa : req.xb;
      hi_raw     = (req.xa < req.xb) ? req.xb : req.xa;
      hi         = (hi_raw > X_MAX) ? X_MAX : hi_raw;
      span_empty = (lo > X_MAX);
   end

   assign last_px = (x == x_last);

   // Next-state logic for the span walk.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (fill_start) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = span_empty ? S_DONE : S_WRITE;
         S_WRITE: if (wr_ready && last_px) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_REARM;
         S_REARM: if (!fill_start) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register; reset abandons any span in flight.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Request capture, span setup and pixel cursor.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         req    <= '0;
         x      <= '0;
         x_last <= '0;
         base   <= '0;
      end else begin
         if (state == S_IDLE && fill_start) begin
            req <= '{row: row_y, xa: x_a, xb: x_b, color: color};
         end
         if (state == S_LOAD && !span_empty) begin
            x      <= lo;
            x_last <= hi;
            // Widen before multiplying so the row offset is never truncated.
            base   <= ADDR_W'(req.row) * STRIDE;
         end
         // Cursor only moves on an accepted write, so a stall holds the address.
         if (state == S_WRITE && wr_ready && !last_px) x <= x + X_W'(1);
      end
   end

   assign wr_en     = (state == S_WRITE);
   assign wr_addr   = wr_en ? base + ADDR_W'(x) : '0;
   assign wr_data   = wr_en ? req.color : '0;
   assign fill_done = (state == S_DONE);
   assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_fill_span_engine.sv
// tb_fill_span_engine: directed spans against a queue-based pixel model.
module tb_fill_span_engine;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        fill_start = 1'b0;
   logic [8:0]  row_y = '0;
   logic [9:0]  x_a = '0;
   logic [9:0]  x_b = '0;
   logic [7:0]  color = '0;
   logic        wr_ready = 1'b1;
   logic        wr_en;
   logic [18:0] wr_addr;
   logic [7:0]  wr_data;
   logic        fill_done;
   logic        busy;

   fill_span_engine #(.X_W(10), .Y_W(9), .SCREEN_W(640), .COLOR_W(8), .ADDR_W(19)) dut (
      .clk(clk), .n_rst(n_rst), .fill_start(fill_start), .row_y(row_y),
      .x_a(x_a), .x_b(x_b), .color(color), .wr_ready(wr_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .fill_done(fill_done), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint addr;
      longint data;
   } wr_t;

   wr_t    exp_q[$];
   longint wr_log[$];
   int     total = 0;
   int     bad = 0;
   int     cyc = 0;
   int     n_wr = 0;
   int     n_done = 0;
   int     stall_cnt = 0;
   int     first_wr_cyc = -1;
   int     done_cyc = -1;
   bit     done_pend = 1'b0;

   task automatic chk_eq(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Cycle counter: value seen after an edge is the index of the cycle it opens.
   always @(posedge clk) cyc <= cyc + 1;

   // Compare process: every write must be the model's next pixel; fill_done
   // only once, and only after the last expected pixel.
   always @(negedge clk) begin
      if (n_rst) begin
         if (wr_en) begin
            chk_eq("wr_expected", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               chk_eq("wr_addr", longint'(wr_addr), exp_q[0].addr);
               chk_eq("wr_data", longint'(wr_data), exp_q[0].data);
               if (wr_ready) begin
                  void'(exp_q.pop_front());
                  wr_log.push_back(longint'(wr_addr));
                  n_wr++;
                  if (first_wr_cyc < 0) first_wr_cyc = cyc;
               end else begin
                  stall_cnt++;
               end
            end
         end
         if (fill_done) begin
            chk_eq("done_expected", longint'(done_pend), 1);
            chk_eq("done_after_last_px", longint'(exp_q.size()), 0);
            done_pend = 1'b0;
            n_done++;
            done_cyc = cyc;
         end
      end
   end

   // Model a span from the rules: order, clip at 639, empty if start is off-screen.
   task automatic load_model(input int row, input int xa, input int xb, input int col);
      int lo, hi;
      wr_t e;
      lo = (xa < xb) ? xa : xb;
      hi = (xa < xb) ? xb : xa;
      if (hi > 639) hi = 639;
      if (lo <= 639) begin
         for (int x = lo; x <= hi; x++) begin
            e.addr = longint'(row) * 640 + longint'(x);
            e.data = longint'(col);
            exp_q.push_back(e);
         end
      end
      done_pend    = 1'b1;
      wr_log.delete();
      first_wr_cyc = -1;
      done_cyc     = -1;
      n_wr         = 0;
      stall_cnt    = 0;
   endtask

   // Run one span; keep fill_start high for 'hold' extra cycles after done.
   task automatic run_span(input int row, input int xa, input int xb, input int col,
                           input int hold, output int s);
      load_model(row, xa, xb, col);
      row_y      = row[8:0];
      x_a        = xa[9:0];
      x_b        = xb[9:0];
      color      = col[7:0];
      fill_start = 1'b1;
      s          = cyc;
      @(posedge clk); #1;
      // Inputs after the sample cycle must have no effect.
      row_y = 9'($urandom_range(511));
      x_a   = 10'($urandom_range(1023));
      x_b   = 10'($urandom_range(1023));
      color = 8'($urandom_range(255));
      for (int i = 0; i < 2000 && done_cyc < 0; i++) begin
         @(posedge clk); #1;
      end
      chk_eq("done_seen", longint'(done_cyc >= 0), 1);
      for (int i = 0; i < hold; i++) begin
         chk_eq("rearm_busy", longint'(busy), 1);
         @(posedge clk); #1;
      end
      chk_eq("rearm_busy", longint'(busy), 1);
      fill_start = 1'b0;
      @(posedge clk); #1;
      chk_eq("idle_not_busy", longint'(busy), 0);
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, nd;
      #3;
      chk_eq("rst_wr_en", longint'(wr_en), 0);
      chk_eq("rst_fill_done", longint'(fill_done), 0);
      chk_eq("rst_busy", longint'(busy), 0);
      chk_eq("rst_wr_addr", longint'(wr_addr), 0);
      @(posedge clk); #1;
      @(posedge clk); #3;
      n_rst = 1'b1;
      @(posedge clk); #1;

      // 1: basic span row 2, x 5..8
      run_span(2, 5, 8, 8'h3C, 0, s);
      chk_eq("t1_nwr", n_wr, 4);
      chk_eq("t1_addr0", wr_log[0], 1285);
      chk_eq("t1_addr3", wr_log[3], 1288);
      chk_eq("t1_first_lat", first_wr_cyc - s, 2);
      chk_eq("t1_done_lat", done_cyc - s, 6);

      // 2: swapped endpoints
      run_span(0, 20, 17, 8'h55, 0, s);
      chk_eq("t2_nwr", n_wr, 4);
      chk_eq("t2_addr0", wr_log[0], 17);
      chk_eq("t2_addr3", wr_log[3], 20);

      // 3a: single pixel in the last screen location
      run_span(479, 639, 639, 8'hA5, 0, s);
      chk_eq("t3a_nwr", n_wr, 1);
      chk_eq("t3a_addr", wr_log[0], 307199);
      chk_eq("t3a_done_lat", done_cyc - s, 3);

      // 3b: fully off-screen span
      run_span(10, 700, 650, 8'h11, 0, s);
      chk_eq("t3b_nwr", n_wr, 0);
      chk_eq("t3b_done_lat", done_cyc - s, 2);

      // 3c: span partly off-screen is clipped at 639
      run_span(1, 630, 900, 8'h22, 0, s);
      chk_eq("t3c_nwr", n_wr, 10);
      chk_eq("t3c_last", wr_log[9], 1279);

      // 4: stall three cycles on the second pixel
      fork
         run_span(0, 10, 12, 8'h77, 0, s);
         begin
            repeat (3) @(posedge clk);
            #1 wr_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 wr_ready = 1'b1;
         end
      join
      chk_eq("t4_nwr", n_wr, 3);
      chk_eq("t4_stall", stall_cnt, 3);
      chk_eq("t4_addr1", wr_log[1], 11);
      chk_eq("t4_done_lat", done_cyc - s, 8);

      // 5: fill_start held after done must not retrigger
      nd = n_done;
      run_span(4, 0, 2, 8'h99, 5, s);
      chk_eq("t5_nwr", n_wr, 3);
      chk_eq("t5_ndone", n_done - nd, 1);
      run_span(5, 3, 3, 8'h42, 0, s);
      chk_eq("t5_next_first", first_wr_cyc - s, 2);
      chk_eq("t5_next_addr", wr_log[0], 3203);

      // 6: reset in the middle of a long span
      load_model(3, 0, 100, 8'hEE);
      row_y = 9'd3; x_a = 10'd0; x_b = 10'd100; color = 8'hEE;
      fill_start = 1'b1;
      s = cyc;
      repeat (20) @(posedge clk);
      #1;
      chk_eq("t6_nwr_before_rst", n_wr, 18);
      nd = n_done;
      n_rst = 1'b0;
      exp_q.delete();
      done_pend = 1'b0;
      fill_start = 1'b0;
      #1;
      chk_eq("t6_rst_wr_en", longint'(wr_en), 0);
      chk_eq("t6_rst_done", longint'(fill_done), 0);
      chk_eq("t6_rst_busy", longint'(busy), 0);
      repeat (2) @(posedge clk);
      #3 n_rst = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk_eq("t6_no_done_after_rst", n_done - nd, 0);
      chk_eq("t6_idle_busy", longint'(busy), 0);
      run_span(1, 0, 3, 8'h0F, 0, s);
      chk_eq("t6_clean_nwr", n_wr, 4);
      chk_eq("t6_clean_first", first_wr_cyc - s, 2);
      chk_eq("t6_clean_addr0", wr_log[0], 640);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
